mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester arbiter sharing the single 32-bit word memory slave port.
- Requester 0 is the CPU-side byte-to-word sizer; requester 1 is the S/PDIF audio buffer DMA engine.
- Round-robin on ties; a grant is held until the slave acks or the owner drops its select.
- Sits between both requesters and the block RAM controller. Adds one arbitration cycle per access.

Parameters:
- ADR_WIDTH, 16, width of all address buses.
- TIMEOUT_CYCLES, 255, maximum grant length without slave ack. Used only with MEM_ARB_TIMEOUT_EN; valid range 1..255.

Ports:
- clk_i  in  1  memory sub-system clock.
- reset_i  in  1  asynchronous, active-high reset.
- m0_sel_i  in  1  requester 0 access request, held until ack.
- m0_adr_i  in  ADR_WIDTH  requester 0 word-aligned address.
- m0_we_i  in  1  requester 0 write (1) / read (0).
- m0_dat_i  in  32  requester 0 write data.
- m0_dat_o  out  32  requester 0 read data.
- m0_ack_o  out  1  requester 0 access complete.
- m0_err_o  out  1  requester 0 timeout abort (optional feature).
- m1_sel_i, m1_adr_i, m1_we_i, m1_dat_i, m1_dat_o, m1_ack_o, m1_err_o: same as m0, for requester 1.
- slave_sel_o  out  1  access strobe to memory.
- slave_adr_o  out  ADR_WIDTH  address to memory.
- slave_we_o  out  1  write enable to memory.
- slave_dat_o  out  32  write data to memory.
- slave_dat_i  in  32  read data from memory.
- slave_ack_i  in  1  memory ack; may be delayed for wait states.

Behaviour:
- FSM, one-hot: IDLE, GNT0, GNT1. last_gnt: 1-bit register.
- Reset (asynchronous): state=IDLE, last_gnt=1, timeout counter=0. All outputs 0 while reset is high.
- IDLE, arbitration (registered):
  - Only m0_sel_i high: GNT0.
  - Only m1_sel_i high: GNT1.
  - Both high: grant the requester that is not last_gnt. First tie after reset goes to m0.
  - Neither high: stay in IDLE.
  - last_gnt updates on entry to GNTx.
- GNTx:
  - slave_sel_o = mx_sel_i.
  - slave_adr_o, slave_we_o, slave_dat_o are combinational muxes of requester x.
  - mx_ack_o = slave_ack_i & mx_sel_i.
  - The other requester's ack and err outputs are 0.
- GNTx exit:
  - slave_ack_i high with mx_sel_i high: IDLE next cycle. One dead cycle between grants is mandatory.
  - mx_sel_i drops without ack: abort to IDLE, no ack issued. Slave outputs go to 0 in the same cycle.
- Outside a grant, all slave outputs are 0.
- Read data: m0_dat_o = m1_dat_o = slave_dat_i (broadcast). Only valid when the matching ack is high.
- Latency: sel high at edge N gives grant at N+1. With a zero-wait slave, ack is in the cycle after edge N+1, and the next grant is no earlier than N+3.
- A requester must not change adr/we/dat while sel is high. The arbiter does not register these signals.
- Reset mid-grant: immediate IDLE, slave_sel_o low, no ack or err emitted.
- Back-to-back requests from both requesters alternate 0,1,0,1.
- A lone requester gets every other cycle (grant, IDLE, grant).

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- With the macro defined:
  - An 8-bit counter clears on entry to GNTx and increments each GNTx cycle without ack.
  - When it reaches TIMEOUT_CYCLES: mx_err_o is high for that one cycle, mx_ack_o stays 0, and the next state is IDLE.
  - Ack in the same cycle as the timeout wins: ack issued, no err.
- Without the macro: m0_err_o = m1_err_o = 0 constant, no counter logic, TIMEOUT_CYCLES ignored.

Test Plan:
- Reset released, m0 reads 0x0010, slave acks one cycle after sel with data 0xDEADBEEF -> m0_ack_o pulses once, m0_dat_o=0xDEADBEEF, slave_adr_o=0x0010, slave_we_o=0.
- m0 and m1 both request continuously, zero-wait slave -> grants alternate m0,m1,m0,m1 with one IDLE cycle between grants. m1 never sees ack while m0 is granted.
- m1 write adr 0x0100, dat 0x12345678 while m0 idle, slave inserts 3 wait cycles -> slave_we_o=1 and slave_dat_o=0x12345678 held 4 cycles, m1_ack_o high only in the 4th.
- m0 granted, m0 drops sel before ack -> state IDLE next cycle, no m0_ack_o. A pending m1 request is granted the cycle after.
- reset_i asserted asynchronously mid-GNT1 -> slave_sel_o falls without a clock edge. After release the first tie goes to m0.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, slave never acks m0 -> m0_err_o pulses in the 4th grant cycle, then m1 is granted. Without the macro, m0 waits indefinitely and err stays 0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Purpose : port bundle of the two-requester memory arbiter (both requesters + memory slave port).
// Latency : n/a (wiring only).
// Backpressure: requesters hold sel until ack/err; memory stretches accesses by delaying slave_ack_i.
// Ports   : m0_*/m1_* requester buses (sel/adr/we/dat in, dat/ack/err out), slave_* memory bus.
// Modports: slave  = arbiter view; master = requesters + memory controller view.
interface mem_arbiter_if #(
  parameter int ADR_WIDTH = 16
);
  // requester 0 (CPU byte-to-word sizer)
  logic                 m0_sel_i;
  logic [ADR_WIDTH-1:0] m0_adr_i;
  logic                 m0_we_i;
  logic [31:0]          m0_dat_i;
  logic [31:0]          m0_dat_o;
  logic                 m0_ack_o;
  logic                 m0_err_o;
  // requester 1 (S/PDIF buffer DMA)
  logic                 m1_sel_i;
  logic [ADR_WIDTH-1:0] m1_adr_i;
  logic                 m1_we_i;
  logic [31:0]          m1_dat_i;
  logic [31:0]          m1_dat_o;
  logic                 m1_ack_o;
  logic                 m1_err_o;
  // shared memory slave port
  logic                 slave_sel_o;
  logic [ADR_WIDTH-1:0] slave_adr_o;
  logic                 slave_we_o;
  logic [31:0]          slave_dat_o;
  logic [31:0]          slave_dat_i;
  logic                 slave_ack_i;

  modport slave (
    input  m0_sel_i, m0_adr_i, m0_we_i, m0_dat_i,
    output m0_dat_o, m0_ack_o, m0_err_o,
    input  m1_sel_i, m1_adr_i, m1_we_i, m1_dat_i,
    output m1_dat_o, m1_ack_o, m1_err_o,
    output slave_sel_o, slave_adr_o, slave_we_o, slave_dat_o,
    input  slave_dat_i, slave_ack_i
  );

  modport master (
    output m0_sel_i, m0_adr_i, m0_we_i, m0_dat_i,
    input  m0_dat_o, m0_ack_o, m0_err_o,
    output m1_sel_i, m1_adr_i, m1_we_i, m1_dat_i,
    input  m1_dat_o, m1_ack_o, m1_err_o,
    input  slave_sel_o, slave_adr_o, slave_we_o, slave_dat_o,
    output slave_dat_i, slave_ack_i
  );
endinterface

// File: rtl/mem_arbiter.sv
// Purpose : round-robin arbiter giving two requesters access to one 32-bit word memory port.
// Latency : one registered arbitration cycle per access, plus one mandatory dead cycle between grants.
// Backpressure: grant held until slave ack or owner drops sel; losing requester simply waits with sel high.
// Ports   : clk_i, reset_i (async, active-high), bus (mem_arbiter_if.slave: m0_*, m1_*, slave_*).
// Option  : define MEM_ARB_TIMEOUT_EN to abort grants lasting TIMEOUT_CYCLES cycles without ack (mx_err_o).
module mem_arbiter #(
  parameter int ADR_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk_i,
  input  logic          reset_i,
  mem_arbiter_if.slave  bus
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT_CYCLES must be within 1..255");
  end

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    GNT0 = 3'b010,
    GNT1 = 3'b100
  } state_e;

  state_e state_q, state_d;
  logic   last_gnt_q, last_gnt_d;

  logic   gnt0;     // requester 0 owns the bus and still holds sel
  logic   gnt1;
  logic   own_sel;
  logic   ack_hit;
  logic   tmo_hit;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
`endif

  assign gnt0    = (state_q == GNT0) & bus.m0_sel_i;
  assign gnt1    = (state_q == GNT1) & bus.m1_sel_i;
  assign own_sel = gnt0 | gnt1;
  assign ack_hit = own_sel & bus.slave_ack_i;

`ifdef MEM_ARB_TIMEOUT_EN
  // cnt_q holds the number of completed unacked grant cycles, so the current
  // cycle is the TIMEOUT_CYCLES-th one when cnt_q == TIMEOUT_CYCLES-1.
  // A same-cycle ack takes priority over the timeout.
  assign tmo_hit = own_sel & ~bus.slave_ack_i & (cnt_q == 8'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    case (state_q)
      IDLE: begin
        // On a tie the requester that did not own the last grant wins.
        if (bus.m0_sel_i && (!bus.m1_sel_i || last_gnt_q)) begin
          state_d    = GNT0;
          last_gnt_d = 1'b0;
        end else if (bus.m1_sel_i) begin
          state_d    = GNT1;
          last_gnt_d = 1'b1;
        end
      end
      GNT0, GNT1: begin
        // Completion, abort (sel dropped) and timeout all return to IDLE,
        // which forces the dead cycle between grants.
        if (!own_sel || ack_hit || tmo_hit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef MEM_ARB_TIMEOUT_EN
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = 8'd0;
    end else if (!bus.slave_ack_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q      <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  // Slave side: muxes are gated by the owner's sel so an abort zeroes the
  // bus in the same cycle the owner lets go.
  assign bus.slave_sel_o = own_sel;
  assign bus.slave_adr_o = gnt0 ? bus.m0_adr_i : (gnt1 ? bus.m1_adr_i : '0);
  assign bus.slave_we_o  = gnt0 ? bus.m0_we_i  : (gnt1 ? bus.m1_we_i  : 1'b0);
  assign bus.slave_dat_o = gnt0 ? bus.m0_dat_i : (gnt1 ? bus.m1_dat_i : 32'd0);

  // Requester side: read data is broadcast, qualified only by the owner's ack.
  assign bus.m0_ack_o = gnt0 & bus.slave_ack_i;
  assign bus.m1_ack_o = gnt1 & bus.slave_ack_i;
  assign bus.m0_dat_o = reset_i ? 32'd0 : bus.slave_dat_i;
  assign bus.m1_dat_o = reset_i ? 32'd0 : bus.slave_dat_i;

`ifdef MEM_ARB_TIMEOUT_EN
  assign bus.m0_err_o = gnt0 & tmo_hit;
  assign bus.m1_err_o = gnt1 & tmo_hit;
`else
  assign bus.m0_err_o = 1'b0;
  assign bus.m1_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose : scoreboard bench for mem_arbiter: directed transfers, per-requester expected-response queues.
// Latency : checks grant/ack timing against hand-computed cycle offsets.
// Backpressure: behavioural memory with programmable wait states or a hang (never acks).
module tb_mem_arbiter;
  localparam int AW  = 16;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADR_WIDTH(AW)) bus();

  mem_arbiter #(.ADR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus.slave)
  );

  // behavioural memory
  int          wait_states = 0;
  bit          hang        = 1'b0;
  logic [31:0] rd_data     = 32'h0;
  int          wcnt;
  always @(posedge clk or posedge rst) begin
    if (rst)                                        wcnt <= 0;
    else if (bus.slave_sel_o && !bus.slave_ack_i)   wcnt <= wcnt + 1;
    else                                            wcnt <= 0;
  end
  assign bus.slave_ack_i = bus.slave_sel_o && !hang && (wcnt == wait_states);
  assign bus.slave_dat_i = rd_data;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] adr;
    logic          we;
    logic [31:0]   dat;
    logic          err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   ack_log[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   wr_hold = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic resp(input int p);
    return (p == 0) ? (bus.m0_ack_o | bus.m0_err_o) : (bus.m1_ack_o | bus.m1_err_o);
  endfunction

  task automatic check_resp(input int p);
    exp_t        e;
    logic        ack, err;
    logic [31:0] dout;
    ack  = (p == 0) ? bus.m0_ack_o : bus.m1_ack_o;
    err  = (p == 0) ? bus.m0_err_o : bus.m1_err_o;
    dout = (p == 0) ? bus.m0_dat_o : bus.m1_dat_o;
    ack_log.push_back(p);
    if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_resp: port %0d ack=%b err=%b, expected no response (cycle %0d)", p, ack, err, cyc);
      return;
    end
    e = (p == 0) ? q0.pop_front() : q1.pop_front();
    chk($sformatf("p%0d_err", p), {31'd0, err}, {31'd0, e.err});
    chk($sformatf("p%0d_ack", p), {31'd0, ack}, {31'd0, ~e.err});
    if (!e.err) begin
      chk($sformatf("p%0d_slave_adr", p), {16'd0, bus.slave_adr_o}, {16'd0, e.adr});
      chk($sformatf("p%0d_slave_we", p), {31'd0, bus.slave_we_o}, {31'd0, e.we});
      if (e.we) chk($sformatf("p%0d_slave_wdat", p), bus.slave_dat_o, e.dat);
      else      chk($sformatf("p%0d_rdat", p), dout, e.dat);
    end
  endtask

  // monitor: decoupled from stimulus, pops whenever a requester sees a response
  always @(negedge clk) begin
    if (!rst) begin
      if (resp(0) || resp(1)) chk("dual_resp", {31'd0, resp(0) & resp(1)}, 32'd0);
      if (resp(0)) check_resp(0);
      if (resp(1)) check_resp(1);
      if (bus.slave_sel_o && bus.slave_we_o && bus.slave_adr_o == 16'h0100 &&
          bus.slave_dat_o == 32'h12345678) wr_hold <= wr_hold + 1;
    end
  end

  task automatic drive(input int p, input logic s, input logic [AW-1:0] a, input logic w, input logic [31:0] d);
    if (p == 0) begin
      bus.m0_sel_i = s; bus.m0_adr_i = a; bus.m0_we_i = w; bus.m0_dat_i = d;
    end else begin
      bus.m1_sel_i = s; bus.m1_adr_i = a; bus.m1_we_i = w; bus.m1_dat_i = d;
    end
  endtask

  task automatic push_exp(input int p, input logic [AW-1:0] a, input logic w, input logic [31:0] d, input logic e);
    exp_t x;
    x.adr = a; x.we = w; x.dat = d; x.err = e;
    if (p == 0) q0.push_back(x);
    else        q1.push_back(x);
  endtask

  // bounded wait for ack/err; returns the cycle number it was seen in
  task automatic wait_resp(input int p, output int seen);
    bit got = 1'b0;
    seen = -1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (resp(p)) begin
        got  = 1'b1;
        seen = cyc;
      end
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL resp_timeout: port %0d got no ack/err, expected one within 100 cycles", p);
    end
  endtask

  // issue one access with sel held; returns at posedge+1 after the response, sel still high
  task automatic do_xfer(input int p, input logic [AW-1:0] a, input logic w, input logic [31:0] d,
                         input logic [31:0] rd_exp, output int seen);
    push_exp(p, a, w, w ? d : rd_exp, 1'b0);
    drive(p, 1'b1, a, w, d);
    wait_resp(p, seen);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int k, seen, seen1, d, start, h0;
    int exp_seq[6];
    drive(0, 1'b0, '0, 1'b0, 32'd0);
    drive(1, 1'b0, '0, 1'b0, 32'd0);
    rd_data = 32'hFFFF_FFFF;

    // reset state: everything quiet, read data gated
    repeat (2) @(negedge clk);
    chk("rst_slave_sel", {31'd0, bus.slave_sel_o}, 32'd0);
    chk("rst_acks", {30'd0, bus.m0_ack_o, bus.m1_ack_o}, 32'd0);
    chk("rst_m0_dat", bus.m0_dat_o, 32'd0);
    chk("rst_m1_dat", bus.m1_dat_o, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_slave_sel", {31'd0, bus.slave_sel_o}, 32'd0);

    // m0 read 0x0010, zero-wait memory
    @(posedge clk); #1;
    rd_data = 32'hDEADBEEF;
    k = cyc;
    do_xfer(0, 16'h0010, 1'b0, 32'd0, 32'hDEADBEEF, seen);
    drive(0, 1'b0, '0, 1'b0, 32'd0);
    chk("m0_read_latency", seen - k, 32'd1);
    repeat (2) @(posedge clk); #1;

    // m1 write 0x0100 with 3 wait states
    wait_states = 3;
    h0 = wr_hold;
    k = cyc;
    do_xfer(1, 16'h0100, 1'b1, 32'h12345678, 32'd0, seen);
    drive(1, 1'b0, '0, 1'b0, 32'd0);
    chk("m1_wait_latency", seen - k, 32'd4);
    chk("m1_wr_hold_cycles", wr_hold - h0, 32'd4);
    wait_states = 0;
    repeat (2) @(posedge clk); #1;

    // both requesters back-to-back: alternation with one dead cycle
    rd_data = 32'hA5A5_5A5A;
    start = ack_log.size();
    exp_seq = '{0, 1, 0, 1, 0, 1};
    fork
      begin
        int s0;
        for (int i = 0; i < 3; i++)
          do_xfer(0, 16'h0020 + 16'(i), 1'b1, 32'hC0DE_0000 + i, 32'd0, s0);
        drive(0, 1'b0, '0, 1'b0, 32'd0);
      end
      begin
        int s1, prev;
        prev = -1;
        for (int i = 0; i < 3; i++) begin
          do_xfer(1, 16'h0040 + 16'(i), 1'b0, 32'd0, 32'hA5A5_5A5A, s1);
          if (prev >= 0) chk("m1_ack_spacing", s1 - prev, 32'd4);
          prev = s1;
        end
        drive(1, 1'b0, '0, 1'b0, 32'd0);
      end
    join
    chk("alt_count", ack_log.size() - start, 32'd6);
    for (int i = 0; i < 6; i++)
      if (start + i < ack_log.size())
        chk($sformatf("alt_order_%0d", i), ack_log[start + i], exp_seq[i]);
    repeat (2) @(posedge clk); #1;

    // abort: m0 granted, drops sel before ack; pending m1 follows
    hang = 1'b1;
    push_exp(1, 16'h0300, 1'b0, 32'h0BAD_F00D, 1'b0);
    rd_data = 32'h0BAD_F00D;
    drive(0, 1'b1, 16'h0200, 1'b1, 32'h5555_AAAA);
    drive(1, 1'b1, 16'h0300, 1'b0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("abort_granted_m0", {16'd0, bus.slave_adr_o}, 32'h0000_0200);
    @(posedge clk); #1;
    drive(0, 1'b0, 16'h0200, 1'b1, 32'h5555_AAAA);
    hang = 1'b0;
    d = cyc;
    @(negedge clk);
    chk("abort_slave_sel", {31'd0, bus.slave_sel_o}, 32'd0);
    chk("abort_slave_adr", {16'd0, bus.slave_adr_o}, 32'd0);
    chk("abort_slave_dat", bus.slave_dat_o, 32'd0);
    wait_resp(1, seen1);
    chk("abort_m1_latency", seen1 - d, 32'd2);
    @(posedge clk); #1;
    drive(1, 1'b0, '0, 1'b0, 32'd0);
    repeat (2) @(posedge clk); #1;

`ifdef MEM_ARB_TIMEOUT_EN
    // timeout: memory never acks m0; err in 4th grant cycle, then m1 granted
    hang = 1'b1;
    rd_data = 32'h7777_0001;
    k = cyc;
    fork
      begin
        int se;
        push_exp(0, 16'h0400, 1'b0, 32'd0, 1'b1);
        drive(0, 1'b1, 16'h0400, 1'b0, 32'd0);
        wait_resp(0, se);
        chk("tmo_err_cycle", se - k, 32'd4);
        @(posedge clk); #1;
        drive(0, 1'b0, '0, 1'b0, 32'd0);
        hang = 1'b0;
      end
      begin
        int sm;
        @(posedge clk); #1;
        push_exp(1, 16'h0500, 1'b0, 32'h7777_0001, 1'b0);
        drive(1, 1'b1, 16'h0500, 1'b0, 32'd0);
        wait_resp(1, sm);
        chk("tmo_m1_after", sm - k, 32'd6);
        @(posedge clk); #1;
        drive(1, 1'b0, '0, 1'b0, 32'd0);
      end
    join
`else
    // no timeout build: m0 waits indefinitely, err never rises
    hang = 1'b1;
    drive(0, 1'b1, 16'h0400, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      repeat (4) @(negedge clk);
      chk($sformatf("notmo_err_%0d", i), {31'd0, bus.m0_err_o}, 32'd0);
      chk($sformatf("notmo_sel_%0d", i), {31'd0, bus.slave_sel_o}, 32'd1);
    end
    @(posedge clk); #1;
    drive(0, 1'b0, '0, 1'b0, 32'd0);
    hang = 1'b0;
`endif
    repeat (2) @(posedge clk); #1;

    // asynchronous reset in the middle of a GNT1
    hang = 1'b1;
    drive(1, 1'b1, 16'h0600, 1'b1, 32'hCAFE_0006);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_sel", {31'd0, bus.slave_sel_o}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_sel", {31'd0, bus.slave_sel_o}, 32'd0);
    chk("async_rst_m1_ack_err", {30'd0, bus.m1_ack_o, bus.m1_err_o}, 32'd0);
    drive(1, 1'b0, '0, 1'b0, 32'd0);
    hang = 1'b0;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    rd_data = 32'h1234_0000;
    start = ack_log.size();
    fork
      begin
        int a0;
        do_xfer(0, 16'h0700, 1'b0, 32'd0, 32'h1234_0000, a0);
        drive(0, 1'b0, '0, 1'b0, 32'd0);
      end
      begin
        int a1;
        do_xfer(1, 16'h0800, 1'b1, 32'h0000_0808, 32'd0, a1);
        drive(1, 1'b0, '0, 1'b0, 32'd0);
      end
    join
    if (ack_log.size() >= start + 2) begin
      chk("post_rst_first_tie", ack_log[start], 32'd0);
      chk("post_rst_second", ack_log[start + 1], 32'd1);
    end else begin
      chk("post_rst_ack_count", ack_log.size() - start, 32'd2);
    end

    repeat (3) @(posedge clk); #1;
    chk("scoreboard_empty", q0.size() + q1.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
